branch_resolve_bht: RTL and testbench
=====================================

Name: branch_resolve_bht

Overview:
- Parametrised successor to the branch condition selector in the RISC-V core's EX stage.
- Computes all six RV32I/RV64I branch conditions from operand values and selects one by funct3.
- Registers the outcome and flags a misprediction against the prediction carried with the instruction.
- Holds a direct-mapped table of 2-bit saturating counters, read by fetch and trained at resolve.

Parameters:
XLEN, 32, operand and PC width (32 or 64).
BHT_ENTRIES, 16, number of 2-bit counters; power of two, minimum 2.
IDX_W, $clog2(BHT_ENTRIES), table index width (derived, not overridden).
CNT_W, 16, width of the misprediction statistics counter.

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
hold  in  1  pipeline stall; freezes all state
valid_in  in  1  branch instruction present in EX this cycle
f3  in  3  instruction funct3
rs1_val  in  XLEN  operand 1
rs2_val  in  XLEN  operand 2
ex_pc  in  XLEN  PC of the branch in EX
pred_in  in  1  prediction made at fetch, carried down the pipe
if_pc  in  XLEN  fetch PC for lookup
pred_taken  out  1  prediction for if_pc (combinational table read)
valid_out  out  1  registered resolve valid
taken  out  1  registered actual outcome
mispredict  out  1  registered: valid_out & (taken != registered pred_in)
illegal  out  1  registered: valid_in with f3 of 010 or 011
mispred_cnt  out  CNT_W  saturating count of mispredictions

Behaviour:
- Reset (async, rst=1):
  - valid_out, taken, mispredict, illegal and mispred_cnt go to 0.
  - Every counter goes to 2'b01 (weakly not-taken).
- Conditions, from the current operands:
  - eq = (rs1 == rs2); lt = signed rs1 < rs2; ltu = unsigned rs1 < rs2.
  - BEQ 000 = eq; BNE 001 = ~eq; BLT 100 = lt; BGE 101 = ~lt; BLTU 110 = ltu; BGEU 111 = ~ltu.
  - f3 010 or 011: outcome 0 and illegal = 1.
- Latency:
  - Outputs are registered with 1 cycle latency: inputs sampled at edge N appear after edge N.
  - valid_out follows valid_in. When valid_in = 0, taken, mispredict and illegal register as 0.
- Hold:
  - hold = 1 at an edge: every output register, table entry and mispred_cnt keeps its value.
  - hold takes priority over valid_in.
- Table index:
  - Lookup uses if_pc[IDX_W+1:2]; training uses ex_pc[IDX_W+1:2].
  - Bits [1:0] are ignored for both.
- Training (valid_in & ~hold & ~illegal):
  - Taken: increment the counter, saturating at 11.
  - Not taken: decrement the counter, saturating at 00.
  - Illegal f3 never trains the table and never counts a misprediction.
- Prediction: pred_taken = counter[1].
- Same-index lookup and train in one cycle: pred_taken returns the pre-update value (no forwarding) unless the optional feature is compiled in.
- mispred_cnt: incremented on the same edge that sets mispredict = 1; saturates at all-ones; no wrap.
- Reset during an active branch: all state clears and the in-flight branch is discarded (valid_out = 0 after release).

Optional Feature:
- Macro: BRANCH_BHT_BYPASS_EN.
- Defined: when valid_in & ~hold & ~illegal and the lookup index equals the training index in the same cycle, pred_taken is bit 1 of the post-update counter value.
- Undefined: pred_taken is always bit 1 of the stored counter. This is one cycle stale on a same-index collision.

Test Plan:
1. Reset, then read every index with no training -> pred_taken = 0 for all 16 entries; mispred_cnt = 0.
2. BLT, rs1 = 32'hFFFFFFFF, rs2 = 1, pred_in = 0 -> next cycle taken = 1, mispredict = 1, mispred_cnt = 1. The same operands with BLTU give taken = 0, mispredict = 0.
3. Three taken BEQ at ex_pc = 32'h40, then one not-taken -> lookup if_pc = 32'h40 gives pred_taken = 1 after 1 train, 1 after 3 trains, and still 1 after the not-taken (counter 11 -> 10). Entry 0x44 is unaffected.
4. f3 = 3'b010 with valid_in = 1 -> illegal = 1, taken = 0, mispredict = 0, table and counter unchanged.
5. hold = 1 with valid_in = 1 and a mispredicting branch -> outputs, table and mispred_cnt unchanged. Deassert hold -> the update applies one cycle later.
6. Same-index collision: counter 01, taken branch trained while if_pc maps to the same index -> pred_taken = 0 without the macro, 1 with BRANCH_BHT_BYPASS_EN. Also assert rst mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_bht
// Description : EX-stage branch resolver with a direct-mapped BHT of 2-bit
//               saturating counters. Evaluates all six branch conditions,
//               selects one by funct3, registers the outcome and misprediction
//               flag, counts mispredictions, and trains the table.
//               Optional macro BRANCH_BHT_BYPASS_EN forwards the post-update
//               counter to pred_taken on a same-index lookup/train collision.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_bht #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             valid_in,
  input  logic [2:0]       f3,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic             pred_in,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic             valid_out,
  output logic             taken,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [1:0] C_CNT_INIT = 2'b01;

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [1:0]       bht_d [BHT_ENTRIES];
  logic             valid_out_q, valid_out_d;
  logic             taken_q, taken_d;
  logic             mispredict_q, mispredict_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             w_eq, w_lt, w_ltu, w_cond, w_illegal, w_train;
  logic [IDX_W-1:0] w_tr_idx, w_lk_idx;
  logic [1:0]       w_cnt_cur, w_cnt_upd;

  // Address bits outside the index field are intentionally ignored.
  logic w_unused_pc_bits;
  assign w_unused_pc_bits = ^{ex_pc[1:0], if_pc[1:0]};

  assign w_tr_idx = ex_pc[IDX_W+1:2];
  assign w_lk_idx = if_pc[IDX_W+1:2];

  // Branch condition evaluation, funct3 select and counter update value.
  always_comb begin
    w_eq      = (rs1_val == rs2_val);
    w_lt      = ($signed(rs1_val) < $signed(rs2_val));
    w_ltu     = (rs1_val < rs2_val);
    w_cond    = 1'b0;
    w_illegal = 1'b0;
    case (f3)
      3'b000:  w_cond = w_eq;
      3'b001:  w_cond = ~w_eq;
      3'b100:  w_cond = w_lt;
      3'b101:  w_cond = ~w_lt;
      3'b110:  w_cond = w_ltu;
      3'b111:  w_cond = ~w_ltu;
      default: w_illegal = 1'b1;
    endcase
    w_train   = valid_in & ~hold & ~w_illegal;
    w_cnt_cur = bht_q[w_tr_idx];
    w_cnt_upd = w_cnt_cur;
    if (w_cond) begin
      if (w_cnt_cur != 2'b11) w_cnt_upd = w_cnt_cur + 2'b01;
    end else begin
      if (w_cnt_cur != 2'b00) w_cnt_upd = w_cnt_cur - 2'b01;
    end
  end

  // Next state for outputs, statistics counter and table; hold freezes all.
  always_comb begin
    valid_out_d   = valid_out_q;
    taken_d       = taken_q;
    mispredict_d  = mispredict_q;
    illegal_d     = illegal_q;
    mispred_cnt_d = mispred_cnt_q;
    for (int i = 0; i < BHT_ENTRIES; i++) bht_d[i] = bht_q[i];
    if (!hold) begin
      valid_out_d  = valid_in;
      taken_d      = valid_in & w_cond;
      illegal_d    = valid_in & w_illegal;
      mispredict_d = w_train & (w_cond != pred_in);
      if (mispredict_d && (mispred_cnt_q != {CNT_W{1'b1}}))
        mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_train) bht_d[w_tr_idx] = w_cnt_upd;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_q   <= 1'b0;
      taken_q       <= 1'b0;
      mispredict_q  <= 1'b0;
      illegal_q     <= 1'b0;
      mispred_cnt_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= C_CNT_INIT;
    end else begin
      valid_out_q   <= valid_out_d;
      taken_q       <= taken_d;
      mispredict_q  <= mispredict_d;
      illegal_q     <= illegal_d;
      mispred_cnt_q <= mispred_cnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

  // Fetch-side prediction; stale on a same-index collision unless bypassed.
  always_comb begin
`ifdef BRANCH_BHT_BYPASS_EN
    if (w_train && (w_lk_idx == w_tr_idx)) pred_taken = w_cnt_upd[1];
    else                                   pred_taken = bht_q[w_lk_idx][1];
`else
    pred_taken = bht_q[w_lk_idx][1];
`endif
  end

  assign valid_out   = valid_out_q;
  assign taken       = taken_q;
  assign mispredict  = mispredict_q;
  assign illegal     = illegal_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_bht
// Description : Directed bench for branch_resolve_bht with a behavioural
//               reference model compared every cycle plus literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_bht;

  localparam int XLEN = 32;
  localparam int ENT  = 16;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, hold, valid_in, pred_in;
  logic [2:0]       f3;
  logic [XLEN-1:0]  rs1_val, rs2_val, ex_pc, if_pc;
  logic             pred_taken, valid_out, taken, mispredict, illegal;
  logic [CNT_W-1:0] mispred_cnt;

  int vectors = 0;
  int miscompares = 0;

  branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hold(hold), .valid_in(valid_in), .f3(f3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .ex_pc(ex_pc), .pred_in(pred_in),
    .if_pc(if_pc), .pred_taken(pred_taken), .valid_out(valid_out),
    .taken(taken), .mispredict(mispredict), .illegal(illegal),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_bht [ENT];
  bit          m_vo, m_tk, m_mp, m_il;
  int unsigned m_cnt;

  function automatic bit m_cond(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_ill(input logic [2:0] f);
    return (f == 3'd2) || (f == 3'd3);
  endfunction

  function automatic int m_next(input int c, input bit t);
    if (t) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic bit m_pred();
    int li, c;
    li = int'((if_pc >> 2) % ENT);
    c  = m_bht[li];
`ifdef BRANCH_BHT_BYPASS_EN
    if (valid_in && !hold && !m_ill(f3) && li == int'((ex_pc >> 2) % ENT))
      c = m_next(c, m_cond(f3, rs1_val, rs2_val));
`endif
    return c >= 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vo = 0; m_tk = 0; m_mp = 0; m_il = 0; m_cnt = 0;
      for (int i = 0; i < ENT; i++) m_bht[i] = 1;
    end else if (!hold) begin
      bit c, il;
      int ti;
      c  = m_cond(f3, rs1_val, rs2_val);
      il = m_ill(f3);
      ti = int'((ex_pc >> 2) % ENT);
      m_vo = valid_in;
      m_tk = valid_in && c;
      m_il = valid_in && il;
      m_mp = valid_in && !il && (c != pred_in);
      if (m_mp && m_cnt < (2**CNT_W - 1)) m_cnt++;
      if (valid_in && !il) m_bht[ti] = m_next(m_bht[ti], c);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out",   valid_out,   m_vo);
      chk("taken",       taken,       m_tk);
      chk("mispredict",  mispredict,  m_mp);
      chk("illegal",     illegal,     m_il);
      chk("mispred_cnt", mispred_cnt, m_cnt);
      chk("pred_taken",  pred_taken,  m_pred());
    end
  end

  // ---------------- stimulus ----------------
  task automatic br(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                    input logic [XLEN-1:0] pc, input logic p);
    valid_in = 1; f3 = f; rs1_val = a; rs2_val = b; ex_pc = pc; pred_in = p;
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic look(input logic [XLEN-1:0] pc, input logic exp, input string name);
    if_pc = pc; #1;
    chk(name, pred_taken, exp);
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic t; } vec_t;
  vec_t tbl [8] = '{
    '{3'd0, 32'd5,        32'd5,        1'b1},
    '{3'd1, 32'd5,        32'd5,        1'b0},
    '{3'd5, 32'h80000000, 32'd0,        1'b0},
    '{3'd7, 32'h80000000, 32'd0,        1'b1},
    '{3'd4, 32'd0,        32'h80000000, 1'b0},
    '{3'd6, 32'd0,        32'h80000000, 1'b1},
    '{3'd5, 32'd7,        32'd7,        1'b1},
    '{3'd7, 32'd3,        32'd7,        1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; hold = 0; valid_in = 0; pred_in = 0; f3 = 0;
    rs1_val = 0; rs2_val = 0; ex_pc = 0; if_pc = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: reset state, every entry weakly not-taken
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_cnt", mispred_cnt, 0);
    for (int i = 0; i < ENT; i++) look(32'(i * 4), 1'b0, "rst_pred");

    // 2: signed vs unsigned compare
    br(3'b100, 32'hFFFFFFFF, 32'd1, 32'h100, 1'b0);
    chk("blt_taken", taken, 1'b1);
    chk("blt_mispredict", mispredict, 1'b1);
    chk("blt_cnt", mispred_cnt, 1);
    br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h100, 1'b0);
    chk("bltu_taken", taken, 1'b0);
    chk("bltu_mispredict", mispredict, 1'b0);

    // 3: training at 0x40 (index 0, counter back at 01)
    if_pc = 32'h40;
    br(3'b000, 32'd5, 32'd5, 32'h40, 1'b1);
    look(32'h40, 1'b1, "train1_pred");
    br(3'b000, 32'd5, 32'd5, 32'h40, 1'b1);
    br(3'b000, 32'd5, 32'd5, 32'h40, 1'b1);
    look(32'h40, 1'b1, "train3_pred");
    br(3'b000, 32'd5, 32'd6, 32'h40, 1'b0);
    look(32'h40, 1'b1, "train_nt_pred");
    look(32'h44, 1'b0, "neighbour_pred");

    // 4: illegal funct3
    br(3'b010, 32'd1, 32'd1, 32'h40, 1'b1);
    chk("ill_illegal", illegal, 1'b1);
    chk("ill_taken", taken, 1'b0);
    chk("ill_mispredict", mispredict, 1'b0);
    chk("ill_cnt", mispred_cnt, 1);
    look(32'h40, 1'b1, "ill_pred");

    // 5: hold freezes everything, release applies the update
    if_pc = 32'h44;
    valid_in = 1; hold = 1; f3 = 3'b001; rs1_val = 1; rs2_val = 2; ex_pc = 32'h44; pred_in = 0;
    @(posedge clk); #1;
    chk("hold_illegal", illegal, 1'b1);
    chk("hold_mispredict", mispredict, 1'b0);
    chk("hold_cnt", mispred_cnt, 1);
    hold = 0;
    @(posedge clk); #1;
    valid_in = 0;
    chk("unhold_taken", taken, 1'b1);
    chk("unhold_mispredict", mispredict, 1'b1);
    chk("unhold_cnt", mispred_cnt, 2);
    look(32'h44, 1'b1, "unhold_pred");

    // condition table at index 15
    foreach (tbl[i]) begin
      br(tbl[i].f, tbl[i].a, tbl[i].b, 32'h3C, 1'b0);
      chk("cond_taken", taken, tbl[i].t);
    end

    // 6: same-index collision at 0x48 (counter 01)
    valid_in = 1; f3 = 3'b000; rs1_val = 9; rs2_val = 9; ex_pc = 32'h48; if_pc = 32'h48; pred_in = 0;
    #1;
`ifdef BRANCH_BHT_BYPASS_EN
    chk("collide_pred", pred_taken, 1'b1);
`else
    chk("collide_pred", pred_taken, 1'b0);
`endif
    @(posedge clk); #1;
    chk("collide_after", pred_taken, 1'b1);
    chk("pre_rst_valid", valid_out, 1'b1);
    rst = 1; #1;
    chk("arst_valid_out", valid_out, 1'b0);
    chk("arst_taken", taken, 1'b0);
    chk("arst_mispredict", mispredict, 1'b0);
    chk("arst_cnt", mispred_cnt, 0);
    @(posedge clk); #1;
    valid_in = 0; rst = 0;
    @(posedge clk); #1;
    chk("post_rst_valid", valid_out, 1'b0);
    look(32'h48, 1'b0, "post_rst_pred");

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
